// File: rtl/m68k_ram_pkg.sv
// Shared types and constants for the 68000-to-byte-RAM bridge.
package m68k_ram_pkg;

  localparam int ADDR_W_DEFAULT = 12;

  // Index into the two-bit strobe vector: bit UPPER is the even byte (D15:8).
  localparam int UPPER = 0;
  localparam int LOWER = 1;

  typedef enum logic [2:0] {
    IDLE,
    HI,
    LO,
    CAP,
    ACK
  } state_t;

endpackage

// File: rtl/m68k_ram_bridge_if.sv
// CPU bus and RAM port of the bridge; slave = the bridge, master = CPU + RAM side.
interface m68k_ram_bridge_if #(
  parameter int ADDR_W = m68k_ram_pkg::ADDR_W_DEFAULT
);

  logic              cs;
  logic              rw;
  logic              uds_n;
  logic              lds_n;
  logic [ADDR_W-2:0] addr;
  logic [15:0]       data_in;
  logic [15:0]       data_out;
  logic              dtack_n;
  logic              ram_ce;
  logic              ram_oce;
  logic              ram_reset;
  logic              ram_wre;
  logic [ADDR_W-1:0] ram_ad;
  logic [7:0]        ram_din;
  logic [7:0]        ram_dout;

  modport slave (
    input  cs, rw, uds_n, lds_n, addr, data_in, ram_dout,
    output data_out, dtack_n, ram_ce, ram_oce, ram_reset, ram_wre, ram_ad, ram_din
  );

  modport master (
    output cs, rw, uds_n, lds_n, addr, data_in, ram_dout,
    input  data_out, dtack_n, ram_ce, ram_oce, ram_reset, ram_wre, ram_ad, ram_din
  );

endinterface

// File: rtl/m68k_ram_bridge.sv
// Splits 68000 word/byte cycles into two sequential 8-bit RAM accesses with fixed DTACK latency.
// Optional RAM_BYTE_SKIP_EN skips the phase of an inactive byte lane for a shorter acknowledge.
module m68k_ram_bridge
  import m68k_ram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  m68k_ram_bridge_if.slave bus
);

  state_t            r_state;
  state_t            w_next;

  logic              r_rw;
  logic [1:0]        r_strb;
  logic [ADDR_W-2:0] r_addr;
  logic [15:0]       r_wdata;
  logic [15:0]       r_rdata;
  logic              r_dtack_n;
  logic              r_ce;
  logic              r_wre;
  logic [ADDR_W-1:0] r_ad;
  logic [7:0]        r_din;
  logic              r_capHi;
  logic              r_capLo;

  logic [1:0]        w_strbIn;
  logic              w_rw;
  logic [1:0]        w_strb;
  logic [ADDR_W-2:0] w_addr;
  logic [15:0]       w_wdata;
  logic              w_ce;
  logic              w_wre;
  logic [ADDR_W-1:0] w_ad;
  logic [7:0]        w_din;
  logic              w_capHi;
  logic              w_capLo;

  assign w_strbIn = {~bus.lds_n, ~bus.uds_n};

  // The first RAM phase is set up on the same edge that latches the request,
  // so in IDLE the live bus is used instead of the (not yet loaded) latch.
  assign w_rw    = (r_state == IDLE) ? bus.rw      : r_rw;
  assign w_strb  = (r_state == IDLE) ? w_strbIn    : r_strb;
  assign w_addr  = (r_state == IDLE) ? bus.addr    : r_addr;
  assign w_wdata = (r_state == IDLE) ? bus.data_in : r_wdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (bus.cs) begin
`ifdef RAM_BYTE_SKIP_EN
          if (!w_strbIn[UPPER] && !w_strbIn[LOWER]) w_next = ACK;
          else if (!w_strbIn[UPPER])                w_next = LO;
          else                                      w_next = HI;
`else
          w_next = HI;
`endif
        end
      end
      HI: begin
        if (!bus.cs) w_next = IDLE;
`ifdef RAM_BYTE_SKIP_EN
        else if (!r_strb[LOWER]) w_next = CAP;
`endif
        else w_next = LO;
      end
      LO:      w_next = bus.cs ? CAP : IDLE;
      CAP:     w_next = bus.cs ? ACK : IDLE;
      ACK:     w_next = bus.cs ? ACK : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // RAM controls are computed for the state being entered so that they are
  // registered and stable for the whole cycle that the RAM samples at its end.
  always_comb begin
    w_ce  = 1'b0;
    w_wre = 1'b0;
    w_ad  = r_ad;
    w_din = r_din;
    case (w_next)
      HI: begin
        w_ad  = {w_addr, 1'b0};
        w_ce  = w_strb[UPPER];
        w_wre = w_strb[UPPER] & ~w_rw;
        w_din = w_wdata[15:8];
      end
      LO: begin
        w_ad  = {w_addr, 1'b1};
        w_ce  = w_strb[LOWER];
        w_wre = w_strb[LOWER] & ~w_rw;
        w_din = w_wdata[7:0];
      end
      default: ;
    endcase
    w_capHi = (r_state == HI) && (w_next != IDLE) && r_rw && r_strb[UPPER];
    w_capLo = (r_state == LO) && (w_next != IDLE) && r_rw && r_strb[LOWER];
  end

  // Read bytes arrive one cycle after the RAM samples the address; the capture
  // flags remember which lane is due and an abort (cs low) suppresses the capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rw      <= 1'b0;
      r_strb    <= 2'b00;
      r_addr    <= '0;
      r_wdata   <= 16'h0000;
      r_rdata   <= 16'h0000;
      r_dtack_n <= 1'b1;
      r_ce      <= 1'b0;
      r_wre     <= 1'b0;
      r_ad      <= '0;
      r_din     <= 8'h00;
      r_capHi   <= 1'b0;
      r_capLo   <= 1'b0;
    end else begin
      if (r_state == IDLE && bus.cs) begin
        r_rw    <= bus.rw;
        r_strb  <= w_strbIn;
        r_addr  <= bus.addr;
        r_wdata <= bus.data_in;
      end
      r_ce    <= w_ce;
      r_wre   <= w_wre;
      r_ad    <= w_ad;
      r_din   <= w_din;
      r_capHi <= w_capHi;
      r_capLo <= w_capLo;
      if (bus.cs && r_capHi) r_rdata[15:8] <= bus.ram_dout;
      if (bus.cs && r_capLo) r_rdata[7:0]  <= bus.ram_dout;
      r_dtack_n <= !((r_state == ACK) && bus.cs);
    end
  end

  assign bus.data_out  = r_rdata;
  assign bus.dtack_n   = r_dtack_n;
  assign bus.ram_ce    = r_ce;
  assign bus.ram_oce   = 1'b1;
  assign bus.ram_reset = 1'b0;
  assign bus.ram_wre   = r_wre;
  assign bus.ram_ad    = r_ad;
  assign bus.ram_din   = r_din;

endmodule

// File: tb/tb_m68k_ram_bridge.sv
// Scoreboard bench for m68k_ram_bridge with a behavioural 4K x 8 bypass-mode RAM.
// Latency expectations follow RAM_BYTE_SKIP_EN when it is defined.
module tb_m68k_ram_bridge;

  typedef struct packed {
    logic [11:0] ad;
    logic        wre;
    logic [7:0]  din;
  } ev_t;

  logic clk;
  logic reset_n;
  int   nCmp;
  int   nFail;

  logic [7:0]  mem [0:4095];
  ev_t         evLog [$];
  ev_t         evExp [$];
  logic [15:0] rdQ   [$];

  m68k_ram_bridge_if #(.ADDR_W(12)) bus ();

  m68k_ram_bridge #(.ADDR_W(12)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM in bypass mode: one-cycle read latency, write data appears on dout.
  always @(posedge clk) begin
    if (bus.ram_ce) begin
      if (bus.ram_wre) begin
        mem[bus.ram_ad] <= bus.ram_din;
        bus.ram_dout    <= bus.ram_din;
      end else begin
        bus.ram_dout <= mem[bus.ram_ad];
      end
    end
  end

  // Every enabled RAM cycle is logged between edges, where the controls are stable.
  always @(negedge clk) begin
    if (bus.ram_ce === 1'b1)
      evLog.push_back('{ad: bus.ram_ad, wre: bus.ram_wre, din: (bus.ram_wre ? bus.ram_din : 8'h00)});
  end

  task automatic runCycle(input logic rwIn, input logic udsN, input logic ldsN,
                          input logic [10:0] a, input logic [15:0] d,
                          input logic [15:0] expRd, input string name);
    int  lat;
    int  expLat;
    ev_t e;
    ev_t got;
    if (rwIn) rdQ.push_back(expRd);
    if (!udsN) evExp.push_back('{ad: {a, 1'b0}, wre: ~rwIn, din: (rwIn ? 8'h00 : d[15:8])});
    if (!ldsN) evExp.push_back('{ad: {a, 1'b1}, wre: ~rwIn, din: (rwIn ? 8'h00 : d[7:0])});
    expLat = 4;
`ifdef RAM_BYTE_SKIP_EN
    if (udsN && ldsN)      expLat = 1;
    else if (udsN || ldsN) expLat = 3;
`endif
    @(negedge clk);
    evLog.delete();
    bus.cs = 1'b1; bus.rw = rwIn; bus.uds_n = udsN; bus.lds_n = ldsN;
    bus.addr = a; bus.data_in = d;
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        bus.addr = ~a; bus.data_in = ~d; bus.uds_n = ~udsN; bus.lds_n = ~ldsN; bus.rw = ~rwIn;
      end
      if (bus.dtack_n === 1'b0) begin lat = k; break; end
    end
    nCmp++;
    if (lat != expLat) begin
      nFail++;
      $display("[TB] FAIL %s latency: got %0d want %0d", name, lat, expLat);
    end
    if (rwIn) begin
      e.din = 8'h00;
      nCmp++;
      if (bus.data_out !== rdQ[0]) begin
        nFail++;
        $display("[TB] FAIL %s data_out: got %h want %h", name, bus.data_out, rdQ[0]);
      end
      void'(rdQ.pop_front());
    end
    @(negedge clk);
    bus.cs = 1'b0;
    @(posedge clk); #1;
    nCmp++;
    if (bus.dtack_n !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL %s dtack release: got %b want 1", name, bus.dtack_n);
    end
    while (evExp.size() > 0) begin
      e = evExp.pop_front();
      nCmp++;
      if (evLog.size() == 0) begin
        nFail++;
        $display("[TB] FAIL %s ram event: got none want ad=%h wre=%b din=%h", name, e.ad, e.wre, e.din);
      end else begin
        got = evLog.pop_front();
        if (got !== e) begin
          nFail++;
          $display("[TB] FAIL %s ram event: got ad=%h wre=%b din=%h want ad=%h wre=%b din=%h",
                   name, got.ad, got.wre, got.din, e.ad, e.wre, e.din);
        end
      end
    end
    nCmp++;
    if (evLog.size() != 0) begin
      nFail++;
      $display("[TB] FAIL %s extra ram events: got %0d want 0", name, evLog.size());
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.cs = 1'b0; bus.rw = 1'b1; bus.uds_n = 1'b1; bus.lds_n = 1'b1;
    bus.addr = '0; bus.data_in = 16'h0000; bus.ram_dout = 8'h00;
    repeat (2) @(negedge clk);
    nCmp++;
    if ({bus.dtack_n, bus.data_out, bus.ram_ce, bus.ram_wre, bus.ram_ad, bus.ram_din,
         bus.ram_oce, bus.ram_reset} !== {1'b1, 16'h0000, 1'b0, 1'b0, 12'h000, 8'h00, 1'b1, 1'b0}) begin
      nFail++;
      $display("[TB] FAIL reset_state: got dtack=%b dout=%h ce=%b wre=%b ad=%h din=%h oce=%b rst=%b want 1/0000/0/0/000/00/1/0",
               bus.dtack_n, bus.data_out, bus.ram_ce, bus.ram_wre, bus.ram_ad, bus.ram_din,
               bus.ram_oce, bus.ram_reset);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_word_access();
    runCycle(1'b0, 1'b0, 1'b0, 11'h012, 16'hBEEF, 16'h0000, "word_write");
    runCycle(1'b1, 1'b0, 1'b0, 11'h012, 16'h0000, 16'hBEEF, "word_read");
  endtask

  task automatic test_byte_lanes();
    runCycle(1'b0, 1'b1, 1'b0, 11'h012, 16'h1234, 16'h0000, "lds_write");
    runCycle(1'b1, 1'b0, 1'b0, 11'h012, 16'h0000, 16'hBE34, "word_read_after_lds");
    runCycle(1'b0, 1'b0, 1'b1, 11'h012, 16'h55AA, 16'h0000, "uds_write");
    runCycle(1'b1, 1'b0, 1'b1, 11'h012, 16'h0000, 16'h5534, "uds_read");
    runCycle(1'b1, 1'b1, 1'b0, 11'h012, 16'h0000, 16'h5534, "lds_read");
    runCycle(1'b1, 1'b1, 1'b1, 11'h012, 16'h0000, 16'h5534, "no_strobe_read");
  endtask

  task automatic test_abort();
    int  lowSeen;
    ev_t e;
    ev_t got;
    evExp.push_back('{ad: 12'h200, wre: 1'b1, din: 8'hAA});
    evExp.push_back('{ad: 12'h201, wre: 1'b1, din: 8'hAA});
    @(negedge clk);
    evLog.delete();
    bus.cs = 1'b1; bus.rw = 1'b0; bus.uds_n = 1'b0; bus.lds_n = 1'b0;
    bus.addr = 11'h100; bus.data_in = 16'hAAAA;
    @(negedge clk);
    @(negedge clk);
    bus.cs = 1'b0;
    lowSeen = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (bus.dtack_n !== 1'b1) lowSeen++;
    end
    nCmp++;
    if (lowSeen != 0) begin
      nFail++;
      $display("[TB] FAIL abort_dtack: got %0d low cycles want 0", lowSeen);
    end
    while (evExp.size() > 0) begin
      e = evExp.pop_front();
      nCmp++;
      if (evLog.size() == 0) begin
        nFail++;
        $display("[TB] FAIL abort ram event: got none want ad=%h", e.ad);
      end else begin
        got = evLog.pop_front();
        if (got !== e) begin
          nFail++;
          $display("[TB] FAIL abort ram event: got ad=%h wre=%b din=%h want ad=%h wre=%b din=%h",
                   got.ad, got.wre, got.din, e.ad, e.wre, e.din);
        end
      end
    end
    nCmp++;
    if (evLog.size() != 0) begin
      nFail++;
      $display("[TB] FAIL abort extra ram events: got %0d want 0", evLog.size());
    end
    runCycle(1'b1, 1'b0, 1'b0, 11'h100, 16'h0000, 16'hAAAA, "abort_readback");
  endtask

  task automatic test_back_to_back();
    logic [10:0] a;
    logic [15:0] d;
    for (int i = 0; i < 3; i++) begin
      a = 11'(9'h180 + $urandom_range(0, 63));
      d = 16'($urandom);
      runCycle(1'b0, 1'b0, 1'b0, a, d, 16'h0000, "b2b_write");
      runCycle(1'b1, 1'b0, 1'b0, a, 16'h0000, d, "b2b_read");
    end
  endtask

  task automatic test_async_reset();
    int lat;
    rdQ.push_back(16'h5534);
    @(negedge clk);
    bus.cs = 1'b1; bus.rw = 1'b1; bus.uds_n = 1'b0; bus.lds_n = 1'b0;
    bus.addr = 11'h012;
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (bus.dtack_n === 1'b0) begin lat = k; break; end
    end
    nCmp++;
    if (lat != 4 || bus.data_out !== rdQ[0]) begin
      nFail++;
      $display("[TB] FAIL pre_reset_read: got lat=%0d data=%h want lat=4 data=%h", lat, bus.data_out, rdQ[0]);
    end
    void'(rdQ.pop_front());
    #1 reset_n = 1'b0;
    #1;
    nCmp++;
    if ({bus.dtack_n, bus.data_out, bus.ram_ce} !== {1'b1, 16'h0000, 1'b0}) begin
      nFail++;
      $display("[TB] FAIL async_reset: got dtack=%b dout=%h ce=%b want 1/0000/0",
               bus.dtack_n, bus.data_out, bus.ram_ce);
    end
    bus.cs = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    runCycle(1'b1, 1'b0, 1'b0, 11'h100, 16'h0000, 16'hAAAA, "post_reset_read");
  endtask

  initial begin
    nCmp  = 0;
    nFail = 0;
    test_reset();
    test_word_access();
    test_byte_lanes();
    test_abort();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
